// File: rtl/adaptive_filter_stim_source.sv
// Framed stimulus generator (impulse/step/ramp/square) for the diff/integ filter.
// Emits a zero flush before each mode change and switches ctrl_out only at frame boundaries.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no output; waits for start
// S_FLUSH | emitting FLUSH_LEN zero samples with the new ctrl_out value
// S_RUN   | emitting FRAME_LEN pattern samples with latched pattern inputs
module adaptive_filter_stim_source #(
   parameter int DATA_WIDTH = 14,
   parameter int FRAME_LEN  = 256,
   parameter int FLUSH_LEN  = 8,
   parameter int SQ_HALF    = 8
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  mode_req,
   input  logic [1:0]            pattern_sel,
   input  logic [DATA_WIDTH-1:0] amplitude,
   input  logic [DATA_WIDTH-1:0] step,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  ctrl_out,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CNT_MAX = (FRAME_LEN > FLUSH_LEN) ? FRAME_LEN : FLUSH_LEN;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int SW      = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;

   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_LEN - 1);
   localparam logic [SW-1:0] SQ_LAST    = SW'(SQ_HALF - 1);

   localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   localparam logic [1:0] PAT_IMPULSE = 2'd0;
   localparam logic [1:0] PAT_STEP    = 2'd1;
   localparam logic [1:0] PAT_RAMP    = 2'd2;
   localparam logic [1:0] PAT_SQUARE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLUSH = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t                state_r, state_n;
   logic [CW-1:0]         cnt_r, cnt_n;
   logic [SW-1:0]         sq_cnt_r, sq_cnt_n;
   logic                  sq_neg_r, sq_neg_n;
   logic [1:0]            pat_r, pat_n;
   logic [DATA_WIDTH-1:0] amp_r, amp_n;
   logic [DATA_WIDTH-1:0] stp_r, stp_n;
   logic [DATA_WIDTH-1:0] ramp_r, ramp_n;
   logic                  stop_pend_r, stop_pend_n;
   logic [DATA_WIDTH-1:0] data_r, data_n;
   logic                  valid_r, valid_n;
   logic                  ctrl_r, ctrl_n;
   logic                  busy_r, busy_n;
   logic                  fd_r, fd_n;

   logic                  xfer;
   logic                  begin_frame;
   logic                  begin_flush;
   logic                  go_idle;
   logic [DATA_WIDTH-1:0] neg_amp;
   logic [DATA_WIDTH-1:0] ramp_adv;
   logic                  sq_wrap;
   logic                  sq_neg_adv;
   logic [DATA_WIDTH-1:0] run_next;
   logic [DATA_WIDTH-1:0] frame_first;

   assign xfer = valid_r && m_tready;

   // The most negative code has no positive counterpart; clamp its negation.
   assign neg_amp    = (amp_r == S_MIN) ? S_MAX : (~amp_r + 1'b1);
   assign ramp_adv   = ramp_r + stp_r;
   assign sq_wrap    = (sq_cnt_r == '0);
   assign sq_neg_adv = sq_wrap ? ~sq_neg_r : sq_neg_r;

   always_comb begin
      run_next = '0;
      case (pat_r)
         PAT_IMPULSE: run_next = '0;
         PAT_STEP:    run_next = amp_r;
         PAT_RAMP:    run_next = ramp_adv;
         PAT_SQUARE:  run_next = sq_neg_adv ? neg_amp : amp_r;
         default:     run_next = '0;
      endcase
   end

   assign frame_first = (pattern_sel == PAT_RAMP) ? '0 : amplitude;

   always_comb begin
      state_n     = state_r;
      cnt_n       = cnt_r;
      sq_cnt_n    = sq_cnt_r;
      sq_neg_n    = sq_neg_r;
      pat_n       = pat_r;
      amp_n       = amp_r;
      stp_n       = stp_r;
      ramp_n      = ramp_r;
      stop_pend_n = stop_pend_r;
      data_n      = data_r;
      valid_n     = valid_r;
      ctrl_n      = ctrl_r;
      fd_n        = 1'b0;
      begin_frame = 1'b0;
      begin_flush = 1'b0;
      go_idle     = 1'b0;

      if (state_r != S_IDLE && stop) begin
         stop_pend_n = 1'b1;
      end

      case (state_r)
         S_IDLE: begin
            if (start) begin
               begin_flush = 1'b1;
            end
         end
         S_FLUSH: begin
            if (xfer) begin
               if (cnt_r == '0) begin
                  if (stop_pend_r) begin
                     go_idle = 1'b1;
                  end else begin
                     begin_frame = 1'b1;
                  end
               end else begin
                  cnt_n  = cnt_r - CW'(1);
                  data_n = '0;
               end
            end
         end
         S_RUN: begin
            if (xfer) begin
               if (cnt_r == '0) begin
                  fd_n = 1'b1;
                  if (stop_pend_r) begin
                     go_idle = 1'b1;
                  end else if (mode_req != ctrl_r) begin
                     begin_flush = 1'b1;
                  end else begin
                     begin_frame = 1'b1;
                  end
               end else begin
                  cnt_n    = cnt_r - CW'(1);
                  ramp_n   = ramp_adv;
                  sq_cnt_n = sq_wrap ? SQ_LAST : (sq_cnt_r - SW'(1));
                  sq_neg_n = sq_neg_adv;
                  data_n   = run_next;
               end
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (begin_flush) begin
         state_n = S_FLUSH;
         cnt_n   = FLUSH_LAST;
         ctrl_n  = mode_req;
         valid_n = 1'b1;
         data_n  = '0;
      end

      // Pattern inputs are sampled only here, so nothing changes mid-frame.
      if (begin_frame) begin
         state_n  = S_RUN;
         cnt_n    = FRAME_LAST;
         pat_n    = pattern_sel;
         amp_n    = amplitude;
         stp_n    = step;
         ramp_n   = '0;
         sq_cnt_n = SQ_LAST;
         sq_neg_n = 1'b0;
         valid_n  = 1'b1;
         data_n   = frame_first;
      end

      if (go_idle) begin
         state_n     = S_IDLE;
         cnt_n       = '0;
         valid_n     = 1'b0;
         data_n      = '0;
         stop_pend_n = 1'b0;
      end
   end

   assign busy_n = (state_n != S_IDLE);

   always_ff @(posedge clk) begin
      if (srst) begin
         state_r     <= S_IDLE;
         cnt_r       <= '0;
         sq_cnt_r    <= '0;
         sq_neg_r    <= 1'b0;
         pat_r       <= '0;
         amp_r       <= '0;
         stp_r       <= '0;
         ramp_r      <= '0;
         stop_pend_r <= 1'b0;
         data_r      <= '0;
         valid_r     <= 1'b0;
         ctrl_r      <= 1'b0;
         busy_r      <= 1'b0;
         fd_r        <= 1'b0;
      end else begin
         state_r     <= state_n;
         cnt_r       <= cnt_n;
         sq_cnt_r    <= sq_cnt_n;
         sq_neg_r    <= sq_neg_n;
         pat_r       <= pat_n;
         amp_r       <= amp_n;
         stp_r       <= stp_n;
         ramp_r      <= ramp_n;
         stop_pend_r <= stop_pend_n;
         data_r      <= data_n;
         valid_r     <= valid_n;
         ctrl_r      <= ctrl_n;
         busy_r      <= busy_n;
         fd_r        <= fd_n;
      end
   end

   assign m_tdata    = data_r;
   assign m_tvalid   = valid_r;
   assign ctrl_out   = ctrl_r;
   assign busy       = busy_r;
   assign frame_done = fd_r;

endmodule

// File: doc/adaptive_filter_stim_source.md
Name: adaptive_filter_stim_source

Overview:
- Streaming stimulus transmitter that feeds the 14-bit sample input of the ctrl-selectable differentiator/integrator filter and drives its ctrl mode line.
- Generates framed test patterns (impulse, step, ramp, square) over a valid/ready handshake.
- Changes filter mode only at frame boundaries, after first emitting a zero-flush so the filter's delay line and feedback loop settle.
- Sits upstream of the filter in the DSP test/bring-up path; m_tready may be tied high when feeding the filter directly.

Parameters:
- DATA_WIDTH, 14, sample width (two's complement).
- FRAME_LEN, 256, samples per RUN frame (≥2).
- FLUSH_LEN, 8, zero samples emitted before each RUN after start or mode change (≥1).
- SQ_HALF, 8, square-wave half period in samples.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- start  in  1  begin generation; ignored unless IDLE.
- stop  in  1  request stop; sticky until honoured.
- mode_req  in  1  requested filter mode (1 = integrator, 0 = differentiator).
- pattern_sel  in  2  0 impulse, 1 step, 2 ramp, 3 square.
- amplitude  in  DATA_WIDTH  signed pattern amplitude.
- step  in  DATA_WIDTH  signed ramp increment.
- m_tdata  out  DATA_WIDTH  sample to filter.
- m_tvalid  out  1  sample valid.
- m_tready  in  1  downstream accept.
- ctrl_out  out  1  filter mode line.
- busy  out  1  high when not IDLE.
- frame_done  out  1  one-cycle pulse on last RUN sample transfer.

Behaviour:
- Reset: state IDLE; m_tvalid=0, m_tdata=0, ctrl_out=0, busy=0, frame_done=0; stop_pending=0; counters=0.
- All outputs are registered.
- Transfer = m_tvalid && m_tready.
- While m_tvalid && !m_tready, m_tdata, m_tvalid and ctrl_out hold stable.
- IDLE → FLUSH: on start (cycle t):
  - ctrl_out latches mode_req at t+1.
  - m_tvalid=1 and m_tdata=0 at t+1.
- FLUSH:
  - Emits FLUSH_LEN zero samples.
  - On the transfer of the last zero, latch pattern_sel, amplitude and step, set n=0, go to RUN.
  - If stop_pending is set, go to IDLE instead.
- RUN:
  - Emits samples n = 0..FRAME_LEN-1.
  - n advances only on transfer.
  - On the transfer of n = FRAME_LEN-1, pulse frame_done, then:
    - stop_pending → IDLE (m_tvalid=0 next cycle, clear stop_pending).
    - else mode_req != ctrl_out → FLUSH; ctrl_out updates at the first flush sample.
    - else restart RUN with n=0 and re-latch the pattern inputs.
- Mode/pattern changes never take effect mid-frame; inputs are sampled only at the boundaries above.
- stop:
  - Sets stop_pending in any non-IDLE state; ignored in IDLE.
  - start and stop asserted together in IDLE: start wins, stop ignored.
  - start while busy: ignored.
- Pattern values (two's complement, DATA_WIDTH bits):
  - Impulse: amplitude at n=0, else 0.
  - Step: amplitude for all n.
  - Ramp: n·step, accumulator starting at 0 each frame, wraps modulo 2^DATA_WIDTH with no saturation.
  - Square: +amplitude when (n / SQ_HALF) is even, else −amplitude. Negating −2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)−1.
- Back-to-back throughput: one sample per clock when m_tready=1, including across FLUSH→RUN, RUN→RUN and RUN→FLUSH boundaries (no bubble).
- srst mid-operation: immediate return to the reset state on the next edge. Any partial frame is discarded and m_tvalid drops.
- busy=1 in FLUSH and RUN, including the final transfer cycle; busy=0 the cycle after the return to IDLE.

Test Plan:
- Reset then idle: srst for 3 cycles, start=0 → m_tvalid=0, m_tdata=0, ctrl_out=0, busy=0 throughout.
- Impulse, m_tready=1, mode_req=1, amplitude=1000, stop pulsed during frame → 8 zeros, then 1000, then 255 zeros; frame_done pulses on the 256th RUN transfer; IDLE after; ctrl_out=1 during all 264 samples.
- Ramp wrap, step=100, FRAME_LEN=256 → sample n=163 equals 16300 mod 16384 = −84 (14'h3FAC); value continues incrementing by 100; next frame restarts at 0.
- Square, amplitude=−8192 → samples 0..7 = −8192, samples 8..15 = +8191 (saturated), repeating.
- Backpressure: m_tready toggled pseudo-randomly → m_tdata/ctrl_out stable while stalled; sequence identical to the m_tready=1 run; exactly 264 transfers.
- Mode change at boundary: mode_req flipped 0→1 mid-frame → ctrl_out stays 0 until the frame ends, then 8 zeros with ctrl_out=1, then the new frame. srst asserted mid-RUN → m_tvalid=0 and busy=0 on the following cycle.
